opb_register_bank_ppc2simulink: RTL
===================================

Name: opb_register_bank_ppc2simulink

Overview:
Software-writable bank of C_NUM_REGS 32-bit registers on the OPB slave bus. Drives a packed parallel output to the Simulink user logic, for example per-channel pulse thresholds for the capture blocks. Writes land in shadow registers, and a control write commits all shadows to the outputs atomically, so multi-word parameter sets never appear half-updated. An optional auto-commit mode updates each output as it is written. Single clock domain: the user logic runs on OPB_Clk.

Parameters:
C_BASEADDR, 32'h01104000, first byte address of the bank
C_HIGHADDR, 32'h011040FF, last byte address decoded (acked)
C_OPB_AWIDTH, 32, OPB address width
C_OPB_DWIDTH, 32, OPB data width (only 32 supported)
C_NUM_REGS, 4, number of user registers (1..62)
C_RESET_VAL, 32'h00000000, reset value of every shadow and output register
C_AUTO_COMMIT, 0, 1 = shadow write also updates its output directly
C_FAMILY, "virtex6", target family (informational)

Ports:
OPB_Clk  in  1  sole clock, bus and user side
OPB_Rst  in  1  synchronous active-high reset
OPB_ABus  in  [0:31]  byte address
OPB_BE  in  [0:3]  byte enables; BE[0] covers DBus[0:7] (value bits 31:24)
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1 = read, 0 = write
OPB_select  in  1  transfer request
OPB_seqAddr  in  1  ignored
Sl_DBus  out  [0:31]  read data, zero when not acking
Sl_errAck  out  1  tied 0
Sl_retry  out  1  tied 0
Sl_toutSup  out  1  tied 0
Sl_xferAck  out  1  one-cycle transfer acknowledge
user_data_out  out  [32*C_NUM_REGS-1:0]  register i on bits [32i+31:32i]
user_data_valid  out  [C_NUM_REGS-1:0]  one-cycle pulse per output updated

Behaviour:
- Reset (OPB_Rst high at a clock edge) forces the following state:
  - all shadows and user_data_out = C_RESET_VAL
  - user_data_valid = 0, Sl_xferAck = 0, Sl_DBus = 0
  - commit_count = 0, ack-done flag clear
- Reset mid-transfer drops any pending ack; the master's bus timeout handles recovery.
- Register map, byte offsets from C_BASEADDR:
  - 4i (i < N): shadow i, R/W
  - 4N: CTRL, write-only, reads 0
  - 4N+4: STATUS, reads {16'h0, commit_count}
  - any other in-range offset: write ignored, read returns 0, still acked
- Decode: hit = OPB_select & (C_BASEADDR <= OPB_ABus <= C_HIGHADDR); low 2 address bits ignored.
- Handshake:
  - Transfer registered on the first hit cycle (T).
  - Sl_xferAck = 1 in cycle T+1 only.
  - Ack-done flag then blocks further acks until OPB_select deasserts.
  - Back-to-back transfers require select low for ≥1 cycle (OPB arbiter guarantees this).
- Read: Sl_DBus carries data in the ack cycle only; value bit 31 maps to DBus[0]. Reading a shadow returns the shadow, not the output.
- Write: at the T+1 edge, only bytes with BE set are updated in the shadow.
- C_AUTO_COMMIT=1 shadow write: the output gets the merged value at T+2, with user_data_valid[i] pulsed in that cycle.
- CTRL write, value bit0 = 1 (DBus[31]) and BE[3] set, commits:
  - at T+2, every user_data_out slice = its shadow
  - user_data_valid = all ones for exactly one cycle
  - commit_count += 1, wrapping 0xFFFF -> 0x0000
- CTRL value bit1 = 1 (same byte) clears all shadows to C_RESET_VAL; outputs are unchanged.
  - If bit0 is also set, clear takes priority; the commit then publishes C_RESET_VAL and still counts.
- With C_AUTO_COMMIT=1 a CTRL commit still pulses all valid bits and counts.
- A bus read never disturbs outputs or valid.
- Outputs hold their value between commits indefinitely.

Test Plan:
1. Reset, then read offset 0 and STATUS -> Sl_xferAck is a single pulse 1 cycle after select; data 0x00000000 for both; user_data_valid stays 0.
2. N=4, AUTO=0:
   - write 0x11111111..0x44444444 to offsets 0x0..0xC -> user_data_out unchanged.
   - write 0x1 to 0x10 -> at T+2 user_data_out = 0x44444444_33333333_22222222_11111111, valid = 4'b1111 for one cycle, STATUS reads 0x0001.
3. Byte enables: shadow0 = 0xAABBCCDD; write 0x11223344 with BE=4'b0101 -> shadow0 reads 0xAA22CC44.
4. AUTO=1: write 0xDEADBEEF to offset 0x8 -> slice [95:64] = 0xDEADBEEF at T+2, valid = 4'b0100 for one cycle; other slices unchanged.
5. OPB_select held 5 cycles on one address -> exactly one Sl_xferAck. Out-of-range address 0x01104100 -> no ack, Sl_DBus = 0. In-range 0x011040F0 -> ack, read 0.
6. Counter wrap and reset:
   - preload 65535 commits, then one more -> STATUS = 0x0000.
   - OPB_Rst asserted on the ack cycle of a commit -> no valid pulse; outputs = C_RESET_VAL.

Source files
------------

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave register bank: software writes land in shadow registers and a CTRL
// write publishes every shadow to the Simulink-facing outputs in one cycle.

module opb_rb_slice #(
   parameter logic [31:0] RESET_VAL = 32'h0,
   parameter bit          AUTO      = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        clr,
   input  logic        commit,
   input  logic [3:0]  be,
   input  logic [31:0] wdata,
   output logic [31:0] shadow,
   output logic [31:0] out,
   output logic        valid
);

   logic [31:0] merged;

   always_comb begin
      merged = shadow;
      for (int b = 0; b < 4; b++)
         if (be[b]) merged[8*b +: 8] = wdata[8*b +: 8];
   end

   // Clear wins over commit, so a clear+commit publishes the reset value.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow <= RESET_VAL;
         out    <= RESET_VAL;
         valid  <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (clr)        shadow <= RESET_VAL;
         else if (wr_en) shadow <= merged;
         if (commit) begin
            out   <= clr ? RESET_VAL : shadow;
            valid <= 1'b1;
         end else if (AUTO && wr_en) begin
            out   <= merged;
            valid <= 1'b1;
         end
      end
   end

endmodule

module opb_register_bank_ppc2simulink #(
   parameter logic [31:0] C_BASEADDR    = 32'h01104000,
   parameter logic [31:0] C_HIGHADDR    = 32'h011040FF,
   parameter int          C_OPB_AWIDTH  = 32,
   parameter int          C_OPB_DWIDTH  = 32,
   parameter int          C_NUM_REGS    = 4,
   parameter logic [31:0] C_RESET_VAL   = 32'h00000000,
   parameter bit          C_AUTO_COMMIT = 1'b0,
   parameter string       C_FAMILY      = "virtex6"
) (
   input  logic                         OPB_Clk,
   input  logic                         OPB_Rst,
   input  logic [0:C_OPB_AWIDTH-1]      OPB_ABus,
   input  logic [0:C_OPB_DWIDTH/8-1]    OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1]      OPB_DBus,
   input  logic                         OPB_RNW,
   input  logic                         OPB_select,
   input  logic                         OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1]      Sl_DBus,
   output logic                         Sl_errAck,
   output logic                         Sl_retry,
   output logic                         Sl_toutSup,
   output logic                         Sl_xferAck,
   output logic [32*C_NUM_REGS-1:0]     user_data_out,
   output logic [C_NUM_REGS-1:0]        user_data_valid
);

   localparam int N = C_NUM_REGS;
   localparam bit unused_family = (C_FAMILY != "");

   logic [31:0]         abus, wdata, offs, rd_val, dbus_q;
   logic [3:0]          be_v;
   logic [29:0]         word, req_word;
   logic                hit, start, ack_done;
   logic                req_rnw, wr_stb, ctrl, commit, clr;
   logic [3:0]          req_be;
   logic [31:0]         req_data;
   logic [15:0]         commit_count;
   logic [N-1:0][31:0]  shadow;
   logic                unused_ok;

   // Bus vectors are big-endian numbered; positional assignment keeps value bit 31 at DBus[0].
   assign abus  = OPB_ABus;
   assign wdata = OPB_DBus;
   assign be_v  = OPB_BE;
   assign offs  = abus - C_BASEADDR;
   assign word  = offs[31:2];
   assign unused_ok = ^{OPB_seqAddr, offs[1:0], unused_family};

   assign hit   = OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
   assign start = hit && !ack_done && !Sl_xferAck;

   always_comb begin
      rd_val = 32'h0;
      for (int i = 0; i < N; i++)
         if (word == 30'(i)) rd_val = shadow[i];
      if (word == 30'(N + 1)) rd_val = {16'h0, commit_count};
   end

   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         Sl_xferAck <= 1'b0;
         ack_done   <= 1'b0;
         dbus_q     <= 32'h0;
         req_word   <= 30'h0;
         req_rnw    <= 1'b1;
         req_be     <= 4'h0;
         req_data   <= 32'h0;
      end else begin
         Sl_xferAck <= start;
         dbus_q     <= (start && OPB_RNW) ? rd_val : 32'h0;
         if (start)            ack_done <= 1'b1;
         else if (!OPB_select) ack_done <= 1'b0;
         if (start) begin
            req_word <= word;
            req_rnw  <= OPB_RNW;
            req_be   <= be_v;
            req_data <= wdata;
         end
      end
   end

   // Register writes take effect on the ack-cycle edge.
   assign wr_stb = Sl_xferAck && !req_rnw;
   assign ctrl   = wr_stb && (req_word == 30'(N)) && req_be[0];
   assign commit = ctrl && req_data[0];
   assign clr    = ctrl && req_data[1];

   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst)     commit_count <= 16'h0;
      else if (commit) commit_count <= commit_count + 16'h1;
   end

   for (genvar i = 0; i < N; i++) begin : g_reg
      opb_rb_slice #(.RESET_VAL(C_RESET_VAL), .AUTO(C_AUTO_COMMIT)) u_slice (
         .clk    (OPB_Clk),
         .rst    (OPB_Rst),
         .wr_en  (wr_stb && (req_word == 30'(i))),
         .clr    (clr),
         .commit (commit),
         .be     (req_be),
         .wdata  (req_data),
         .shadow (shadow[i]),
         .out    (user_data_out[32*i +: 32]),
         .valid  (user_data_valid[i])
      );
   end

   assign Sl_DBus    = dbus_q;
   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;

endmodule
